// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter sharing one uart_tx between NUM_REQ byte-stream requesters.
// Define UART_ARB_TIMEOUT_EN to add the LOCKED watchdog and the o_timeoutCount output.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int DATA_SIZE      = 8,
  parameter int BUSY_WAIT_MAX  = 4,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                         i_clock,
  input  logic                         i_nReset,
  input  logic [NUM_REQ-1:0]           i_reqValid,
  input  logic [NUM_REQ*DATA_SIZE-1:0] i_reqData,
  input  logic [NUM_REQ-1:0]           i_reqLast,
  output logic [NUM_REQ-1:0]           o_reqReady,
  input  logic                         i_txReady,
  output logic [DATA_SIZE-1:0]         o_txData,
  output logic                         o_txValid,
  output logic [NUM_REQ-1:0]           o_grant,
`ifdef UART_ARB_TIMEOUT_EN
  output logic [7:0]                   o_timeoutCount,
`endif
  output logic                         o_busy
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW_W  = (BUSY_WAIT_MAX > 1) ? $clog2(BUSY_WAIT_MAX + 1) : 1;

  typedef enum logic [2:0] {IDLE, LOCKED, SEND, WAIT_BUSY, WAIT_READY} state_t;

  state_t               state_reg, state_next;
  logic [IDX_W-1:0]     ptr_reg, ptr_next;
  logic [IDX_W-1:0]     owner_reg, owner_next;
  logic [NUM_REQ-1:0]   grant_reg, grant_next;
  logic [DATA_SIZE-1:0] data_reg, data_next;
  logic                 last_reg, last_next;
  logic [BW_W-1:0]      busy_cnt_reg, busy_cnt_next;

  logic [DATA_SIZE-1:0] req_data [NUM_REQ];
  logic [IDX_W:0]       rot_sum [NUM_REQ];
  logic [IDX_W-1:0]     rot_idx [NUM_REQ];
  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic                 take;
  logic [IDX_W-1:0]     take_idx;
  logic [IDX_W-1:0]     ptr_adv;
  logic [NUM_REQ-1:0]   ready_onehot;

  // Out-of-range configurations have no meaningful behaviour; this block stays empty.
  if (NUM_REQ < 2 || NUM_REQ > 8 || BUSY_WAIT_MAX < 1 || TIMEOUT_CYCLES < 1) begin : g_param_range
  end

  // rot_idx[i] is the requester examined i-th when searching from the round-robin pointer.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_data[gi] = i_reqData[gi*DATA_SIZE +: DATA_SIZE];
      assign rot_sum[gi]  = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
      assign rot_idx[gi]  = (rot_sum[gi] >= (IDX_W+1)'(NUM_REQ))
                          ? IDX_W'(rot_sum[gi] - (IDX_W+1)'(NUM_REQ))
                          : IDX_W'(rot_sum[gi]);
    end
  endgenerate

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (i_reqValid[rot_idx[i]]) begin
        win_found = 1'b1;
        win_idx   = rot_idx[i];
      end
    end
  end

  assign ptr_adv = (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + IDX_W'(1);

  always_comb begin
    take     = 1'b0;
    take_idx = owner_reg;
    if (state_reg == IDLE) begin
      take     = i_txReady && win_found;
      take_idx = win_idx;
    end else if (state_reg == LOCKED) begin
      take     = i_txReady && i_reqValid[owner_reg];
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] timeout_cnt_reg, timeout_cnt_next;
  logic [7:0]      timeout_count_reg, timeout_count_next;
`endif

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    grant_next    = grant_reg;
    data_next     = data_reg;
    last_next     = last_reg;
    busy_cnt_next = busy_cnt_reg;
    ready_onehot  = '0;
`ifdef UART_ARB_TIMEOUT_EN
    timeout_cnt_next   = '0;
    timeout_count_next = timeout_count_reg;
`endif
    if (take) begin
      ready_onehot[take_idx] = 1'b1;
      owner_next             = take_idx;
      grant_next             = '0;
      grant_next[take_idx]   = 1'b1;
      data_next              = req_data[take_idx];
      last_next              = i_reqLast[take_idx];
      state_next             = SEND;
    end else begin
      case (state_reg)
`ifdef UART_ARB_TIMEOUT_EN
        LOCKED: begin
          if (timeout_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1)) begin
            grant_next = '0;
            ptr_next   = ptr_adv;
            state_next = IDLE;
            if (timeout_count_reg != 8'hFF) timeout_count_next = timeout_count_reg + 8'd1;
          end else begin
            timeout_cnt_next = timeout_cnt_reg + TO_W'(1);
          end
        end
`endif
        SEND: begin
          busy_cnt_next = '0;
          state_next    = WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (!i_txReady || busy_cnt_reg == BW_W'(BUSY_WAIT_MAX - 1)) state_next = WAIT_READY;
          else busy_cnt_next = busy_cnt_reg + BW_W'(1);
        end
        WAIT_READY: begin
          if (i_txReady) begin
            if (last_reg) begin
              grant_next = '0;
              ptr_next   = ptr_adv;
              state_next = IDLE;
            end else begin
              state_next = LOCKED;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      grant_reg    <= '0;
      data_reg     <= '0;
      last_reg     <= 1'b0;
      busy_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      grant_reg    <= grant_next;
      data_reg     <= data_next;
      last_reg     <= last_next;
      busy_cnt_reg <= busy_cnt_next;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  always_ff @(posedge i_clock or negedge i_nReset) begin
    if (!i_nReset) begin
      timeout_cnt_reg   <= '0;
      timeout_count_reg <= '0;
    end else begin
      timeout_cnt_reg   <= timeout_cnt_next;
      timeout_count_reg <= timeout_count_next;
    end
  end
  assign o_timeoutCount = timeout_count_reg;
`endif

  // The accept strobe is combinational, so it is forced low while reset is held.
  assign o_reqReady = ready_onehot & {NUM_REQ{i_nReset}};
  assign o_txData   = data_reg;
  assign o_txValid  = (state_reg == SEND);
  assign o_grant    = grant_reg;
  assign o_busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: requester byte queues and a UART ready model drive the DUT,
// a reference model of the arbitration and handshake rules checks all outputs every cycle.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N   = 3;
  localparam int DW  = 8;
  localparam int BWM = 4;
  localparam int TO  = 100;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic          tx_ready, tx_valid, busy;
  logic [DW-1:0] tx_data;
`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0]    to_count;
`endif

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ(N), .DATA_SIZE(DW), .BUSY_WAIT_MAX(BWM), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clock(clk),
    .i_nReset(rst_n),
    .i_reqValid(req_valid),
    .i_reqData(req_data),
    .i_reqLast(req_last),
    .o_reqReady(req_ready),
    .i_txReady(tx_ready),
    .o_txData(tx_data),
    .o_txValid(tx_valid),
    .o_grant(grant),
`ifdef UART_ARB_TIMEOUT_EN
    .o_timeoutCount(to_count),
`endif
    .o_busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [DW:0]   q [N][$];
  logic [N-1:0]  stall = '0;
  bit            rand_stall = 0;
  bit            u_stuck = 0;
  bit            u_rand = 0;
  int            u_delay = 0;
  int            u_low = 20;
  int            drop_at = -1;
  int            rise_at = -1;
  logic [N-1:0]  saw_rr = '0;
  logic [DW-1:0] plog[$];
  int            ptime[$];
  logic [7:0]    exp_q[$];
  int            base;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: owner (-1 none), rr pointer, cycles since accept (-1 = handshake done).
  int            m_own, m_ptr, m_since, m_lockidle, m_tocnt, m_w;
  bit            m_bdone, m_last;
  logic [DW-1:0] m_data;
  logic [N-1:0]  m_rr;

  task automatic model_reset();
    m_own = -1; m_ptr = 0; m_since = -1; m_bdone = 0; m_last = 0;
    m_data = '0; m_lockidle = 0; m_tocnt = 0;
  endtask

  initial begin
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
        chk("rst_reqReady", req_ready, 0);
        chk("rst_txValid", tx_valid, 0);
        chk("rst_txData", tx_data, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
`ifdef UART_ARB_TIMEOUT_EN
        chk("rst_timeoutCount", to_count, 0);
`endif
      end else begin
        m_w = -1;
        m_rr = '0;
        if (m_since < 0 && tx_ready) begin
          if (m_own < 0) begin
            for (int i = 0; i < N; i++)
              if (m_w < 0 && req_valid[(m_ptr + i) % N]) m_w = (m_ptr + i) % N;
          end else if (req_valid[m_own]) begin
            m_w = m_own;
          end
        end
        if (m_w >= 0) m_rr[m_w] = 1'b1;
        chk("reqReady", req_ready, m_rr);
        chk("txValid", tx_valid, (m_since == 1));
        chk("txData", tx_data, m_data);
        chk("grant", grant, (m_own < 0) ? 32'd0 : (32'd1 << m_own));
        chk("busy", busy, (m_own >= 0));
`ifdef UART_ARB_TIMEOUT_EN
        chk("timeoutCount", to_count, m_tocnt);
`endif
        if (tx_valid) begin
          plog.push_back(tx_data);
          ptime.push_back(cyc);
          $display("tx byte 0x%02h grant %b cycle %0d", tx_data, grant, cyc);
        end
        if (m_w >= 0) begin
          m_own = m_w; m_data = req_data[m_w*DW +: DW]; m_last = req_last[m_w];
          m_since = 1; m_bdone = 0; m_lockidle = 0;
        end else if (m_since == 1) begin
          m_since = 2;
        end else if (m_since >= 2) begin
          if (!m_bdone) begin
            if (!tx_ready || m_since == 1 + BWM) m_bdone = 1;
            else m_since++;
          end else if (tx_ready) begin
            m_since = -1;
            if (m_last) begin m_ptr = (m_own + 1) % N; m_own = -1; end
          end
        end
`ifdef UART_ARB_TIMEOUT_EN
        else if (m_own >= 0) begin
          if (m_lockidle == TO - 1) begin
            m_ptr = (m_own + 1) % N; m_own = -1; m_lockidle = 0;
            if (m_tocnt < 255) m_tocnt++;
          end else begin
            m_lockidle++;
          end
        end
`endif
      end
    end
  end

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      if (q[k].size() > 0 && !stall[k]) begin
        req_valid[k] = 1'b1;
        req_data[k*DW +: DW] = q[k][0][DW-1:0];
        req_last[k] = q[k][0][DW];
      end else begin
        req_valid[k] = 1'b0;
        req_data[k*DW +: DW] = 8'($urandom);
        req_last[k] = 1'($urandom);
      end
    end
    tx_ready = u_stuck || !(cyc >= drop_at && cyc < rise_at);
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    logic pulse;
    int d, l;
    @(negedge clk);
    acc = req_ready & {N{rst_n}};
    pulse = tx_valid;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) if (acc[k] && q[k].size() > 0) void'(q[k].pop_front());
    saw_rr |= acc;
    if (pulse) begin
      d = u_rand ? $urandom_range(0, 5) : u_delay;
      l = u_rand ? $urandom_range(0, 6) : u_low;
      drop_at = cyc + d;
      rise_at = drop_at + l;
    end
    if (rand_stall) for (int k = 0; k < N; k++) stall[k] = ($urandom_range(0, 7) == 0);
    drive_inputs();
  endtask

  function automatic bit all_empty();
    for (int k = 0; k < N; k++) if (q[k].size() != 0) return 0;
    return 1;
  endfunction

  task automatic run_until_idle(input int limit, input string name);
    int n = 0;
    do begin cycle(); n++; end while (!(all_empty() && !busy) && n < limit);
    chk({name, "_done"}, (n < limit), 1);
  endtask

  task automatic wait_pulses(input int target, input int limit, input string name);
    int n = 0;
    while (plog.size() < target && n < limit) begin cycle(); n++; end
    chk({name, "_pulse_wait"}, (plog.size() >= target), 1);
  endtask

  task automatic chk_seq(input string name, input int b, input logic [7:0] e[$]);
    chk({name, "_len"}, plog.size() - b, e.size());
    for (int i = 0; i < e.size(); i++)
      chk($sformatf("%s_byte%0d", name, i), (b + i < plog.size()) ? {24'd0, plog[b + i]} : 32'hDEAD, e[i]);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with a requester valid: accept strobe and registers must stay 0.
    rst_n = 1'b0;
    tx_ready = 1'b1;
    q[0].push_back(9'h141);
    drive_inputs();
    repeat (3) cycle();
    chk("init_reqReady", req_ready, 0);
    chk("init_grant", grant, 0);
    chk("init_busy", busy, 0);
    chk("init_txData", tx_data, 0);
    q[0].delete();
    drive_inputs();
    rst_n = 1'b1;

    // 1: single two-byte frame, UART busy 20 cycles per byte.
    base = plog.size();
    q[0] = '{9'h041, 9'h142};
    drive_inputs();
    run_until_idle(300, "t1");
    exp_q = '{8'h41, 8'h42};
    chk_seq("t1", base, exp_q);
    chk("t1_grant_end", grant, 0);

    // 2: contention from reset, two frames each; the requester that just finished yields.
    rst_n = 1'b0;
    u_low = 3;
    q[0] = '{9'h010, 9'h011, 9'h112, 9'h030, 9'h031, 9'h132};
    q[1] = '{9'h020, 9'h021, 9'h122, 9'h040, 9'h041, 9'h142};
    drive_inputs();
    repeat (2) cycle();
    rst_n = 1'b1;
    base = plog.size();
    run_until_idle(1000, "t2");
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32, 8'h40, 8'h41, 8'h42};
    chk_seq("t2", base, exp_q);

    // 3: owner stalls mid-frame for 50 cycles while another requester waits.
    u_low = 20;
    base = plog.size();
    q[0] = '{9'h050, 9'h051, 9'h152};
    q[1] = '{9'h060, 9'h161};
    drive_inputs();
    wait_pulses(base + 1, 100, "t3");
    stall[0] = 1'b1;
    saw_rr = '0;
    drive_inputs();
    repeat (50) cycle();
    chk("t3_no_tx_while_stalled", plog.size() - base, 1);
    chk("t3_req1_never_ready", saw_rr[1], 0);
    chk("t3_grant_held", grant, 3'b001);
    stall[0] = 1'b0;
    drive_inputs();
    run_until_idle(500, "t3");
    exp_q = '{8'h50, 8'h51, 8'h52, 8'h60, 8'h61};
    chk_seq("t3", base, exp_q);

    // 4: UART never drops ready: busy-wait bound paces one pulse per byte.
    u_stuck = 1;
    base = plog.size();
    q[0] = '{9'h070, 9'h071, 9'h172};
    drive_inputs();
    run_until_idle(300, "t4");
    exp_q = '{8'h70, 8'h71, 8'h72};
    chk_seq("t4", base, exp_q);
    chk("t4_gap0", (ptime.size() >= base + 3) ? ptime[base + 1] - ptime[base] : -1, BWM + 3);
    chk("t4_gap1", (ptime.size() >= base + 3) ? ptime[base + 2] - ptime[base + 1] : -1, BWM + 3);
    u_stuck = 0;

    // 5: asynchronous reset while waiting for ready after byte 2 of 3.
    base = plog.size();
    q[0] = '{9'h080, 9'h081, 9'h182};
    drive_inputs();
    wait_pulses(base + 2, 200, "t5");
    repeat (2) cycle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_grant", grant, 0);
    chk("t5_async_busy", busy, 0);
    chk("t5_async_txValid", tx_valid, 0);
    chk("t5_async_txData", tx_data, 0);
    chk("t5_async_reqReady", req_ready, 0);
    q[0].delete();
    q[1] = '{9'h090, 9'h191};
    drop_at = -1;
    rise_at = -1;
    repeat (2) cycle();
    rst_n = 1'b1;
    drive_inputs();
    run_until_idle(300, "t5");
    exp_q = '{8'h80, 8'h81, 8'h90, 8'h91};
    chk_seq("t5", base, exp_q);

`ifdef UART_ARB_TIMEOUT_EN
    // 6: owner goes silent after a non-last byte; the watchdog hands over to req1.
    u_low = 3;
    base = plog.size();
    q[0] = '{9'h0A0};
    q[1] = '{9'h0B0, 9'h1B1};
    drive_inputs();
    run_until_idle(600, "t6");
    exp_q = '{8'hA0, 8'hB0, 8'hB1};
    chk_seq("t6", base, exp_q);
    chk("t6_timeoutCount", to_count, 1);
`endif

    // Randomized frames, stalls and UART timing.
    u_rand = 1;
    rand_stall = 1;
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 3) != 0) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) q[k].push_back({1'(b == len - 1), 8'($urandom)});
        end
      end
      drive_inputs();
      run_until_idle(3000, "rand");
    end
    rand_stall = 0;
    stall = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
